// File: rtl/ps2_kbd_decoder_pkg.sv
// Shared types and constants for the PS/2 keyboard decoder: receiver states,
// prefix byte values, non-key response codes and the queued key event.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_REL    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PAUSE_CODE = 8'h77;

    // Bytes of the Pause/Break sequence that follow the E1 lead byte.
    localparam int PAUSE_LEN = 7;

    localparam int N_NONKEY = 6;
    localparam logic [N_NONKEY-1:0][7:0] NONKEY_CODES =
        {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

    typedef struct packed {
        logic       rel;
        logic       ext;
        logic [7:0] code;
    } ps2_event_t;

    function automatic logic is_nonkey(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_NONKEY; i++) begin
            if (b == NONKEY_CODES[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_kbd_decoder_if.sv
// Key event handshake between the decoder (master) and the keyboard matrix logic (slave).
interface ps2_kbd_decoder_if;
    logic       key_valid;
    logic       key_ready;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_release;

    modport master (
        output key_valid,
        output key_code,
        output key_ext,
        output key_release,
        input  key_ready
    );

    modport slave (
        input  key_valid,
        input  key_code,
        input  key_ext,
        input  key_release,
        output key_ready
    );
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus debounce: the output level follows the line only
// after FILTER consecutive synchronised samples disagree with it. Idles high.
module ps2_line_filter #(
    parameter int FILTER = 4
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic line_i,
    output logic level_o
);
    localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;

    logic          meta_q;
    logic          sync_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            meta_q  <= line_i;
            sync_q  <= meta_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any sample matching the current level restarts the run count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q != level_q) begin
            if (cnt_q == CW'(FILTER - 1)) level_d = sync_q;
            else                          cnt_d   = cnt_q + 1'b1;
        end
    end

    assign level_o = level_q;
endmodule

// File: rtl/ps2_kbd_decoder.sv
// PS/2 keyboard receiver: frame deserialiser, prefix folding and event FIFO.
//   state  | meaning
//   IDLE   | waiting for a start bit (data low on a clock fall)
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | capturing the odd-parity bit
//   STOP   | checking stop bit and parity, then back to IDLE
module ps2_kbd_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER  = 4,
    parameter int TIMEOUT = 4096,
    parameter int FIFO_AW = 2
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic                      ps2_clk,
    input  logic                      ps2_data,
    ps2_kbd_decoder_if.master         key_if,
    output logic                      frame_err,
    output logic                      overflow,
    output logic [7:0]                err_count
);
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam int DEPTH = 1 << FIFO_AW;

    logic clk_f, data_f, clk_f_q;
    logic clk_fall, clk_edge;

    ps2_line_filter #(.FILTER(FILTER)) u_clk_filt (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .line_i  (ps2_clk),
        .level_o (clk_f)
    );

    ps2_line_filter #(.FILTER(FILTER)) u_data_filt (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .line_i  (ps2_data),
        .level_o (data_f)
    );

    assign clk_fall = clk_f_q & ~clk_f;
    assign clk_edge = clk_f_q ^ clk_f;

    rx_state_e      state_q, state_d;
    logic [2:0]     bitcnt_q, bitcnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           parity_q, parity_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           byte_done_q, byte_done_d;
    logic           frame_err_q, frame_err_d;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_f_q     <= 1'b1;
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            byte_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            clk_f_q     <= clk_f;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            tmo_q       <= tmo_d;
            byte_done_q <= byte_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        byte_done_d = 1'b0;
        frame_err_d = 1'b0;

        if (clk_edge)                    tmo_d = '0;
        else if (tmo_q == TW'(TIMEOUT))  tmo_d = tmo_q;
        else                             tmo_d = tmo_q + 1'b1;

        // A stalled partial frame is abandoned before any further edge is used.
        if (state_q != IDLE && tmo_q == TW'(TIMEOUT)) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
        end else if (clk_fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!data_f) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d  = {data_f, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    parity_d = data_f;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (data_f && (^{shift_q, parity_q})) byte_done_d = 1'b1;
                    else                                  frame_err_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    logic       ext_q, ext_d;
    logic       rel_q, rel_d;
    logic [2:0] pause_q, pause_d;
    logic       push;
    ps2_event_t push_ev;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ext_q   <= 1'b0;
            rel_q   <= 1'b0;
            pause_q <= '0;
        end else begin
            ext_q   <= ext_d;
            rel_q   <= rel_d;
            pause_q <= pause_d;
        end
    end

    always_comb begin
        ext_d   = ext_q;
        rel_d   = rel_q;
        pause_d = pause_q;
        push    = 1'b0;
        push_ev = '0;
        if (frame_err_q) begin
            ext_d = 1'b0;
            rel_d = 1'b0;
        end else if (byte_done_q) begin
            if (pause_q != 3'd0) begin
                pause_d = pause_q - 3'd1;
                if (pause_q == 3'd1) begin
                    push    = 1'b1;
                    push_ev = '{rel: 1'b0, ext: 1'b1, code: PAUSE_CODE};
                end
            end else if (shift_q == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (shift_q == PS2_REL) begin
                rel_d = 1'b1;
            end else if (shift_q == PS2_PAUSE) begin
                pause_d = 3'(PAUSE_LEN);
            end else if (!(is_nonkey(shift_q) && !ext_q && !rel_q)) begin
                push    = 1'b1;
                push_ev = '{rel: rel_q, ext: ext_q, code: shift_q};
                ext_d   = 1'b0;
                rel_d   = 1'b0;
            end
        end
    end

    ps2_event_t           mem_q [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]     count_q;
    logic                 fifo_full, fifo_empty, pop, wr_en;
    logic                 overflow_q;
    logic [7:0]           err_cnt_q;
    ps2_event_t           head;

    assign fifo_full  = (count_q == (FIFO_AW + 1)'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign pop        = ~fifo_empty & key_if.key_ready;
    // A full FIFO still accepts a push in the same cycle its head is popped.
    assign wr_en      = push & (~fifo_full | pop);

    always_ff @(posedge clk_sys) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_ev;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_q + {{FIFO_AW{1'b0}}, wr_en} - {{FIFO_AW{1'b0}}, pop};
            overflow_q <= push & fifo_full & ~pop;
            if (frame_err_d && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign head               = mem_q[rd_ptr_q];
    assign key_if.key_valid   = ~fifo_empty;
    assign key_if.key_code    = fifo_empty ? 8'h00 : head.code;
    assign key_if.key_ext     = ~fifo_empty & head.ext;
    assign key_if.key_release = ~fifo_empty & head.rel;
    assign frame_err          = frame_err_q;
    assign overflow           = overflow_q;
    assign err_count          = err_cnt_q;
endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Bench for ps2_kbd_decoder: drives PS/2 frames, predicts key events from the
// byte stream with a queue-based model and checks every delivered event.
module tb_ps2_kbd_decoder;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } ev_t;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic       frame_err;
    logic       overflow;
    logic [7:0] err_count;

    ps2_kbd_decoder_if kif();

    ps2_kbd_decoder #(.FILTER(4), .TIMEOUT(4096), .FIFO_AW(2)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key_if    (kif),
        .frame_err (frame_err),
        .overflow  (overflow),
        .err_count (err_count)
    );

    always #5 clk_sys = ~clk_sys;

    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    int  seen_err = 0;
    int  seen_ovf = 0;
    int  valid_cycles = 0;
    int  n_deliv = 0;
    int  last_err_cyc = 0;
    ev_t last_ev = '0;

    ev_t exp_q[$];
    bit  m_ext = 0;
    bit  m_rel = 0;
    int  m_pause = 0;
    int  exp_err = 0;
    int  exp_ovf = 0;

    function automatic void check(input bit ok, input string nm, input int act, input int exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endfunction

    function automatic ev_t mk(input logic [7:0] c, input logic e, input logic r);
        ev_t v;
        v.code = c;
        v.ext  = e;
        v.rel  = r;
        return v;
    endfunction

    function automatic int sat8(input int n);
        return (n > 255) ? 255 : n;
    endfunction

    function automatic void model_push(input ev_t v);
        if (exp_q.size() >= 4) exp_ovf++;
        else                   exp_q.push_back(v);
        m_ext = 0;
        m_rel = 0;
    endfunction

    function automatic void model_err();
        exp_err++;
        m_ext = 0;
        m_rel = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (m_pause > 0) begin
            m_pause--;
            if (m_pause == 0) model_push(mk(8'h77, 1'b1, 1'b0));
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_rel = 1;
        end else if (b == 8'hE1) begin
            m_pause = 7;
        end else if (!m_ext && !m_rel &&
                     (b == 8'hAA || b == 8'hFA || b == 8'hEE ||
                      b == 8'hFE || b == 8'h00 || b == 8'hFF)) begin
            // response bytes never become key events
        end else begin
            model_push(mk(b, m_ext, m_rel));
        end
    endfunction

    // Compare process: every accepted head event must be the next predicted one.
    always @(negedge clk_sys) begin
        ev_t got, e;
        cyc++;
        if (reset_n) begin
            if (frame_err) begin
                seen_err++;
                last_err_cyc = cyc;
            end
            if (overflow)      seen_ovf++;
            if (kif.key_valid) valid_cycles++;
            if (kif.key_valid && kif.key_ready) begin
                got = mk(kif.key_code, kif.key_ext, kif.key_release);
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_event", int'(got), 0);
                end else begin
                    e = exp_q.pop_front();
                    check(got == e, "event", int'(got), int'(e));
                end
                last_ev = got;
                n_deliv++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits, input int per);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            tick(per / 2);
            ps2_clk = 1'b0;
            tick(per - per / 2);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    // kind: 0 good frame, 1 wrong parity, 2 stop bit low
    task automatic send_frame(input logic [7:0] b, input int kind, input int per);
        logic        par;
        logic [10:0] bits;
        par = ~^b;
        if (kind == 1) par = ~par;
        bits = {(kind == 2) ? 1'b0 : 1'b1, par, b, 1'b0};
        if (kind == 0) model_byte(b);
        else           model_err();
        send_bits(bits, 11, per);
        tick(per);
    endtask

    task automatic checkpoint(input string tag);
        check(seen_err == exp_err, {tag, "_err_pulses"}, seen_err, exp_err);
        check(int'(err_count) == sat8(exp_err), {tag, "_err_count"}, int'(err_count), sat8(exp_err));
        check(seen_ovf == exp_ovf, {tag, "_overflow"}, seen_ovf, exp_ovf);
        check(exp_q.size() == 0, {tag, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check(kif.key_valid == 1'b0,   {tag, "_key_valid"}, int'(kif.key_valid), 0);
        check(kif.key_code == 8'h00,   {tag, "_key_code"}, int'(kif.key_code), 0);
        check(kif.key_ext == 1'b0,     {tag, "_key_ext"}, int'(kif.key_ext), 0);
        check(kif.key_release == 1'b0, {tag, "_key_release"}, int'(kif.key_release), 0);
        check(frame_err == 1'b0,       {tag, "_frame_err"}, int'(frame_err), 0);
        check(overflow == 1'b0,        {tag, "_overflow"}, int'(overflow), 0);
        check(err_count == 8'h00,      {tag, "_err_count"}, int'(err_count), 0);
    endtask

    initial begin
        int          d0, t0, dt, per, kind;
        logic [7:0]  b;
        logic [7:0]  seq [8];

        reset_n       = 1'b0;
        ps2_clk       = 1'b1;
        ps2_data      = 1'b1;
        kif.key_ready = 1'b1;
        tick(5);
        check_idle_outputs("reset");
        reset_n = 1'b1;
        tick(10);

        // single make code, 42-cycle bit period
        d0 = n_deliv;
        valid_cycles = 0;
        send_frame(8'h1C, 0, 42);
        tick(20);
        check(n_deliv - d0 == 1, "t1_count", n_deliv - d0, 1);
        check(last_ev == mk(8'h1C, 1'b0, 1'b0), "t1_event", int'(last_ev), int'(mk(8'h1C, 1'b0, 1'b0)));
        check(valid_cycles == 1, "t1_valid_cycles", valid_cycles, 1);
        check(seen_err == 0, "t1_no_err", seen_err, 0);
        checkpoint("t1");

        // extended break, then plain make of the same code
        d0 = n_deliv;
        send_frame(8'hE0, 0, 42);
        send_frame(8'hF0, 0, 42);
        send_frame(8'h75, 0, 42);
        check(n_deliv - d0 == 1, "t2_count_a", n_deliv - d0, 1);
        check(last_ev == mk(8'h75, 1'b1, 1'b1), "t2_event_a", int'(last_ev), int'(mk(8'h75, 1'b1, 1'b1)));
        send_frame(8'h75, 0, 42);
        check(last_ev == mk(8'h75, 1'b0, 1'b0), "t2_event_b", int'(last_ev), int'(mk(8'h75, 1'b0, 1'b0)));
        checkpoint("t2");

        // parity error then recovery
        d0 = n_deliv;
        send_frame(8'h1C, 1, 42);
        check(n_deliv - d0 == 0, "t3_no_event", n_deliv - d0, 0);
        check(err_count == 8'd1, "t3_err_count", int'(err_count), 1);
        send_frame(8'h1C, 0, 42);
        check(n_deliv - d0 == 1, "t3_recover", n_deliv - d0, 1);
        checkpoint("t3");

        // start + 3 data bits then the clock stalls high
        d0 = n_deliv;
        model_err();
        send_bits({1'b1, 1'b0, 8'h5A, 1'b0}, 4, 42);
        t0 = cyc;
        tick(5000);
        dt = last_err_cyc - t0;
        check(dt >= 4096 && dt <= 4120, "t4_timeout_latency", dt, 4104);
        check(n_deliv - d0 == 0, "t4_no_event", n_deliv - d0, 0);
        send_frame(8'h29, 0, 42);
        check(last_ev == mk(8'h29, 1'b0, 1'b0), "t4_event", int'(last_ev), int'(mk(8'h29, 1'b0, 1'b0)));
        checkpoint("t4");

        // fill the FIFO, overflow on the fifth, then drain
        d0 = n_deliv;
        kif.key_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 42);
        check(seen_ovf == 1, "t5_overflow_once", seen_ovf, 1);
        check(kif.key_valid == 1'b1, "t5_valid_full", int'(kif.key_valid), 1);
        check(kif.key_code == 8'h01, "t5_head", int'(kif.key_code), 1);
        kif.key_ready = 1'b1;
        tick(10);
        check(n_deliv - d0 == 4, "t5_drained", n_deliv - d0, 4);
        check(last_ev == mk(8'h04, 1'b0, 1'b0), "t5_last", int'(last_ev), int'(mk(8'h04, 1'b0, 1'b0)));
        check(kif.key_valid == 1'b0, "t5_empty", int'(kif.key_valid), 0);
        checkpoint("t5");

        // Pause/Break sequence folds into one event
        d0 = n_deliv;
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        for (int i = 0; i < 8; i++) send_frame(seq[i], 0, 42);
        check(n_deliv - d0 == 1, "t6_count", n_deliv - d0, 1);
        check(last_ev == mk(8'h77, 1'b1, 1'b0), "t6_event", int'(last_ev), int'(mk(8'h77, 1'b1, 1'b0)));
        checkpoint("t6");

        // randomized byte stream with prefixes, response codes and bad frames
        for (int n = 0; n < 30; n++) begin
            per = $urandom_range(30, 70);
            case ($urandom_range(0, 7))
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                2:       b = 8'hE1;
                3: begin
                    case ($urandom_range(0, 5))
                        0: b = 8'hAA;
                        1: b = 8'hFA;
                        2: b = 8'hEE;
                        3: b = 8'hFE;
                        4: b = 8'h00;
                        default: b = 8'hFF;
                    endcase
                end
                default: b = 8'($urandom_range(0, 255));
            endcase
            kind = 0;
            if (m_pause == 0 && $urandom_range(0, 9) == 0) kind = $urandom_range(1, 2);
            send_frame(b, kind, per);
        end
        tick(20);
        checkpoint("rand");

        // reset in the middle of a frame
        send_bits({1'b1, 1'b1, 8'h33, 1'b0}, 5, 42);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        #3 reset_n = 1'b0;
        #3;
        check_idle_outputs("midreset");
        exp_q.delete();
        m_ext = 0;
        m_rel = 0;
        m_pause = 0;
        exp_err = 0;
        exp_ovf = 0;
        seen_err = 0;
        seen_ovf = 0;
        tick(5);
        reset_n = 1'b1;
        tick(10);
        d0 = n_deliv;
        send_frame(8'h4B, 0, 42);
        check(n_deliv - d0 == 1, "t8_count", n_deliv - d0, 1);
        check(last_ev == mk(8'h4B, 1'b0, 1'b0), "t8_event", int'(last_ev), int'(mk(8'h4B, 1'b0, 1'b0)));
        checkpoint("t8");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
